// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU datapath types: machine word, register index, writeback source
// select, and the EX/MEM stage state encoding.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    // Writeback source; PORT_O is the idle/bubble selection.
    typedef enum logic [1:0] {
        ALU_O  = 2'd0,
        PORT_O = 2'd1,
        LOAD_O = 2'd2,
        NPC_O  = 2'd3
    } wdatsel_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } exmem_state_t;

endpackage

// File: rtl/exmem_watchdog.sv
// -----------------------------------------------------------------------------
// exmem_watchdog
// Counts consecutive cycles spent waiting on the data memory and flags a
// timeout in the WAIT_LIMIT-th such cycle. Down-counter with a terminal-count
// compare; reloads whenever the wait is broken.
//
// Ports:
//   CLK        in   clock
//   RST        in   asynchronous active-high reset
//   i_waiting  in   memory access outstanding and not answered this cycle
//   o_timeout  out  this is the WAIT_LIMIT-th consecutive waiting cycle
// -----------------------------------------------------------------------------
module exmem_watchdog #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_waiting,
    output logic o_timeout
);

    localparam int            CW     = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= RELOAD;
        end else if (!i_waiting) begin
            r_count <= RELOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_timeout = i_waiting && (r_count == '0);

endmodule

// File: rtl/exmem_stage.sv
// -----------------------------------------------------------------------------
// exmem_stage
// EX/MEM pipeline register with an embedded data-memory access sequencer.
// Captures execute-stage results, issues a single load/store, stalls the
// upstream stages until dhit, and presents the registered MEM-stage results.
//
// Optional feature: define EXMEM_WATCHDOG_EN to add a memory-wait watchdog
// (timeout after WAIT_LIMIT unanswered ACCESS cycles, sticky wd_err).
//
// state  | meaning
// -------+------------------------------------------
// IDLE   | no access pending; pipeline register live
// ACCESS | memory request outstanding, waiting dhit
//
// Ports:
//   CLK, RST                       clock, async active-high reset
//   enable, flush                  hazard-unit stage controls
//   ex_aluout/ex_rdat2/ex_npc      ALU result, store data, next PC
//   ex_dREN/ex_dWEN/ex_WEN/ex_halt execute-stage control flags
//   ex_wsel, ex_wdatsel            destination register, writeback source
//   dmemREN/dmemWEN                data-memory request
//   dmemaddr/dmemstore             memory address and store data
//   dhit, dmemload                 memory done, load data
//   mem_*                          registered MEM-stage results
//   mem_stall                      freezes upstream stages
//   wd_err                         watchdog timeout, sticky
// -----------------------------------------------------------------------------
module exmem_stage
    import cpu_types_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     enable,
    input  logic     flush,
    input  word_t    ex_aluout,
    input  word_t    ex_rdat2,
    input  word_t    ex_npc,
    input  logic     ex_dREN,
    input  logic     ex_dWEN,
    input  logic     ex_WEN,
    input  logic     ex_halt,
    input  regbits_t ex_wsel,
    input  wdatsel_t ex_wdatsel,
    output logic     dmemREN,
    output logic     dmemWEN,
    output word_t    dmemaddr,
    output word_t    dmemstore,
    input  logic     dhit,
    input  word_t    dmemload,
    output word_t    mem_aluout,
    output word_t    mem_dload,
    output word_t    mem_npc,
    output logic     mem_WEN,
    output logic     mem_halt,
    output logic     mem_valid,
    output regbits_t mem_wsel,
    output wdatsel_t mem_wdatsel,
    output logic     mem_stall,
    output logic     wd_err
);

    generate
        if (WAIT_LIMIT < 1) begin : g_bad_limit
            $error("exmem_stage: WAIT_LIMIT must be at least 1");
        end
    endgenerate

    exmem_state_t r_state, w_state_next;

    word_t    r_aluout, r_rdat2, r_npc, r_dload;
    logic     r_dREN, r_dWEN, r_WEN, r_halt, r_valid;
    regbits_t r_wsel;
    wdatsel_t r_wdatsel;

    logic w_capture, w_bubble, w_take_load, w_wd_trip, w_timeout;
    logic w_access;

    assign w_access = (r_state == ACCESS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Flush outranks enable; a halted stage ignores both. ACCESS never aborts
    // except on a watchdog trip.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_bubble     = 1'b0;
        w_take_load  = 1'b0;
        w_wd_trip    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_halt) begin
                    if (flush) begin
                        w_bubble = 1'b1;
                    end else if (enable) begin
                        w_capture = 1'b1;
                        if (ex_dREN || ex_dWEN) w_state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (dhit) begin
                    w_take_load  = r_dREN;
                    w_state_next = IDLE;
                end else if (w_timeout) begin
                    w_wd_trip    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST || (!RST && w_bubble)) begin
            r_aluout  <= '0;
            r_rdat2   <= '0;
            r_npc     <= '0;
            r_dload   <= '0;
            r_dREN    <= 1'b0;
            r_dWEN    <= 1'b0;
            r_WEN     <= 1'b0;
            r_halt    <= 1'b0;
            r_valid   <= 1'b0;
            r_wsel    <= '0;
            r_wdatsel <= PORT_O;
        end else if (w_capture) begin
            r_aluout  <= ex_aluout;
            r_rdat2   <= ex_rdat2;
            r_npc     <= ex_npc;
            r_dREN    <= ex_dREN;
            r_dWEN    <= ex_dWEN;
            r_WEN     <= ex_WEN;
            r_halt    <= ex_halt;
            r_valid   <= 1'b1;
            r_wsel    <= ex_wsel;
            r_wdatsel <= ex_wdatsel;
        end else if (w_take_load) begin
            r_dload   <= dmemload;
        end else if (w_wd_trip) begin
            r_WEN     <= 1'b0;
        end
    end

    assign dmemREN     = w_access & r_dREN;
    assign dmemWEN     = w_access & r_dWEN;
    assign dmemaddr    = w_access ? r_aluout : '0;
    assign dmemstore   = w_access ? r_rdat2  : '0;
    // Combinational so upstream stages advance in the dhit cycle itself.
    assign mem_stall   = w_access & ~dhit;

    assign mem_aluout  = r_aluout;
    assign mem_dload   = r_dload;
    assign mem_npc     = r_npc;
    assign mem_WEN     = r_WEN;
    assign mem_halt    = r_halt;
    assign mem_valid   = r_valid & ~w_access;
    assign mem_wsel    = r_wsel;
    assign mem_wdatsel = r_wdatsel;

`ifdef EXMEM_WATCHDOG_EN
    logic r_wd_err;

    exmem_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_watchdog (
        .CLK       (CLK),
        .RST       (RST),
        .i_waiting (mem_stall),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            r_wd_err <= 1'b0;
        else if (w_wd_trip) r_wd_err <= 1'b1;
    end

    assign wd_err = r_wd_err;
`else
    assign w_timeout = 1'b0;
    assign wd_err    = 1'b0;
`endif

endmodule
